// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode encodings, default ROB tag width
// and operand-2 immediate decode.
package cpu_defs_pkg;

  localparam int TAG_W_DEF = 4;

  localparam logic [5:0]
    OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB    = 6'd11, OP_LH    = 6'd12,
    OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU   = 6'd15, OP_SB    = 6'd16,
    OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI  = 6'd19, OP_SLTI  = 6'd20,
    OP_SLTIU= 6'd21, OP_XORI  = 6'd22, OP_ORI   = 6'd23, OP_ANDI  = 6'd24,
    OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI  = 6'd27, OP_ADD   = 6'd28,
    OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31, OP_SLTU  = 6'd32,
    OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35, OP_OR    = 6'd36,
    OP_AND  = 6'd37;

  // Ops whose second ALU operand is the immediate rather than rs2.
  function automatic logic op_imm2(input logic [5:0] op);
    return (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR}) ||
           (op >= OP_ADDI && op <= OP_SRAI);
  endfunction

endpackage

// File: rtl/param_reservation_station_age_select.sv
// Oldest-first picker: grants the requester that no other
// requester is older than (age[j][i] = j older than i).
module age_select #(
  parameter int N = 16
) (
  input  logic [N-1:0]        req,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant
);

  always_comb begin
    grant = req;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (j != i && req[j] && age[j][i]) grant[i] = 1'b0;
  end

endmodule

// File: rtl/param_reservation_station.sv
// Unified reservation station: CDB wakeup, age-ordered issue to
// NUM_ALU ALU channels and one back-pressured load/store port.
module param_reservation_station
  import cpu_defs_pkg::*;
#(
  parameter int RS_SIZE = 16,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int NUM_ALU = 2,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [5:0]                 disp_op,
  input  logic                       disp_is_ls,
  input  logic [TAG_W-1:0]           disp_tag,
  input  logic [31:0]                disp_imm,
  input  logic                       disp_q1_busy,
  input  logic                       disp_q2_busy,
  input  logic [TAG_W-1:0]           disp_q1,
  input  logic [TAG_W-1:0]           disp_q2,
  input  logic [31:0]                disp_v1,
  input  logic [31:0]                disp_v2,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*32-1:0]      cdb_value,
  output logic [NUM_ALU-1:0]         alu_valid,
  output logic [NUM_ALU*6-1:0]       alu_op,
  output logic [NUM_ALU*32-1:0]      alu_rs1,
  output logic [NUM_ALU*32-1:0]      alu_rs2,
  output logic [NUM_ALU*TAG_W-1:0]   alu_tag,
  output logic                       ls_valid,
  input  logic                       ls_ready,
  output logic [5:0]                 ls_op,
  output logic [TAG_W-1:0]           ls_tag,
  output logic [31:0]                ls_offset,
  output logic [31:0]                ls_rs1,
  output logic [31:0]                ls_rs2,
  output logic [$clog2(RS_SIZE):0]   free_count
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;

  logic [RS_SIZE-1:0] busy, r1, r2, is_ls;
  logic [5:0]         op  [RS_SIZE];
  logic [TAG_W-1:0]   tag [RS_SIZE], q1 [RS_SIZE], q2 [RS_SIZE];
  logic [31:0]        imm [RS_SIZE], v1 [RS_SIZE], v2 [RS_SIZE];
  logic [RS_SIZE-1:0][RS_SIZE-1:0] age;

  logic [RS_SIZE-1:0] w1, w2;
  logic [31:0]        wv1 [RS_SIZE], wv2 [RS_SIZE];
  logic               d1, d2, imm2, take, ls_load;
  logic [31:0]        dv1, dv2;
  logic [IW-1:0]      slot, l_idx;
  logic [IW-1:0]      a_idx [NUM_ALU];
  logic [RS_SIZE-1:0] ready, req_ls, g_ls, issued;
  logic [RS_SIZE-1:0] req_alu [NUM_ALU], g_alu [NUM_ALU];

  always_comb begin
    free_count = '0;
    slot = '0;
    for (int i = RS_SIZE-1; i >= 0; i--)
      if (!busy[i]) begin
        free_count = free_count + CW'(1);
        slot = IW'(i);
      end
  end

  assign disp_ready = (free_count != '0) && !flush;
  assign take = disp_valid && disp_ready && rdy;
  assign imm2 = !disp_is_ls && op_imm2(disp_op);

  // Descending port scan so the lowest matching port wins.
  always_comb begin
    d1 = 1'b0; dv1 = '0; d2 = 1'b0; dv2 = '0;
    w1 = '0; w2 = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      wv1[i] = '0;
      wv2[i] = '0;
    end
    for (int k = NUM_CDB-1; k >= 0; k--)
      if (cdb_valid[k]) begin
        if (cdb_tag[k*TAG_W +: TAG_W] == disp_q1) begin
          d1 = 1'b1; dv1 = cdb_value[k*32 +: 32];
        end
        if (cdb_tag[k*TAG_W +: TAG_W] == disp_q2) begin
          d2 = 1'b1; dv2 = cdb_value[k*32 +: 32];
        end
        for (int i = 0; i < RS_SIZE; i++) begin
          if (cdb_tag[k*TAG_W +: TAG_W] == q1[i]) begin
            w1[i] = 1'b1; wv1[i] = cdb_value[k*32 +: 32];
          end
          if (cdb_tag[k*TAG_W +: TAG_W] == q2[i]) begin
            w2[i] = 1'b1; wv2[i] = cdb_value[k*32 +: 32];
          end
        end
      end
  end

  assign ready   = busy & r1 & r2;
  assign req_ls  = ready & is_ls;
  assign ls_load = ls_ready || !ls_valid;

  for (genvar c = 0; c < NUM_ALU; c++) begin : g_ch
    if (c == 0) begin : g_first
      assign req_alu[c] = ready & ~is_ls;
    end else begin : g_rest
      assign req_alu[c] = req_alu[c-1] & ~g_alu[c-1];
    end
    age_select #(.N(RS_SIZE)) u_sel (
      .req   (req_alu[c]),
      .age   (age),
      .grant (g_alu[c])
    );
  end

  age_select #(.N(RS_SIZE)) u_ls_sel (
    .req   (req_ls),
    .age   (age),
    .grant (g_ls)
  );

  always_comb begin
    issued = ls_load ? g_ls : '0;
    l_idx = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (g_ls[i]) l_idx = IW'(i);
    for (int c = 0; c < NUM_ALU; c++) begin
      issued = issued | g_alu[c];
      a_idx[c] = '0;
      for (int i = 0; i < RS_SIZE; i++)
        if (g_alu[c][i]) a_idx[c] = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= '0;
      age       <= '0;
      alu_valid <= '0;
      ls_valid  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        busy      <= '0;
        alu_valid <= '0;
        ls_valid  <= 1'b0;
      end else begin
        busy <= (busy & ~issued) |
                (take ? (RS_SIZE'(1) << slot) : '0);
        for (int c = 0; c < NUM_ALU; c++)
          alu_valid[c] <= |g_alu[c];
        if (ls_load) ls_valid <= |g_ls;
        // New entry is younger than everything currently held.
        if (take) begin
          for (int j = 0; j < RS_SIZE; j++)
            age[j][slot] <= busy[j];
          age[slot] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !r1[i] && w1[i]) begin
          r1[i] <= 1'b1; v1[i] <= wv1[i];
        end
        if (busy[i] && !r2[i] && w2[i]) begin
          r2[i] <= 1'b1; v2[i] <= wv2[i];
        end
      end
      if (take) begin
        op[slot]    <= disp_op;
        is_ls[slot] <= disp_is_ls;
        tag[slot]   <= disp_tag;
        imm[slot]   <= disp_imm;
        q1[slot]    <= disp_q1;
        q2[slot]    <= disp_q2;
        r1[slot]    <= !disp_q1_busy || d1;
        v1[slot]    <= disp_q1_busy ? dv1 : disp_v1;
        r2[slot]    <= imm2 || !disp_q2_busy || d2;
        v2[slot]    <= imm2 ? disp_imm :
                       (disp_q2_busy ? dv2 : disp_v2);
      end
      for (int c = 0; c < NUM_ALU; c++)
        if (|g_alu[c]) begin
          alu_op[c*6 +: 6]         <= op[a_idx[c]];
          alu_tag[c*TAG_W +: TAG_W] <= tag[a_idx[c]];
          alu_rs1[c*32 +: 32]      <= v1[a_idx[c]];
          alu_rs2[c*32 +: 32]      <= v2[a_idx[c]];
        end
      if (ls_load && |g_ls) begin
        ls_op     <= op[l_idx];
        ls_tag    <= tag[l_idx];
        ls_offset <= imm[l_idx];
        ls_rs1    <= v1[l_idx];
        ls_rs2    <= v2[l_idx];
      end
    end
  end

endmodule

// File: tb/tb_param_reservation_station.sv
// Bench for param_reservation_station: directed scenarios and random
// traffic checked against an in-order queue model of the station.
module tb_param_reservation_station;
  import cpu_defs_pkg::*;

  localparam int RS = 16, TW = 4, NA = 2, NC = 2;

  logic clk = 1'b0;
  logic rst, rdy, flush;
  logic disp_valid, disp_ready, disp_is_ls;
  logic [5:0] disp_op;
  logic [TW-1:0] disp_tag, disp_q1, disp_q2;
  logic [31:0] disp_imm, disp_v1, disp_v2;
  logic disp_q1_busy, disp_q2_busy;
  logic [NC-1:0] cdb_valid;
  logic [NC*TW-1:0] cdb_tag;
  logic [NC*32-1:0] cdb_value;
  logic [NA-1:0] alu_valid;
  logic [NA*6-1:0] alu_op;
  logic [NA*32-1:0] alu_rs1, alu_rs2;
  logic [NA*TW-1:0] alu_tag;
  logic ls_valid, ls_ready;
  logic [5:0] ls_op;
  logic [TW-1:0] ls_tag;
  logic [31:0] ls_offset, ls_rs1, ls_rs2;
  logic [4:0] free_count;

  always #5 clk = ~clk;

  param_reservation_station #(
    .RS_SIZE(RS), .TAG_W(TW), .NUM_ALU(NA), .NUM_CDB(NC)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_is_ls(disp_is_ls),
    .disp_tag(disp_tag), .disp_imm(disp_imm),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_v1(disp_v1), .disp_v2(disp_v2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_rs1(alu_rs1),
    .alu_rs2(alu_rs2), .alu_tag(alu_tag),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_op(ls_op),
    .ls_tag(ls_tag), .ls_offset(ls_offset), .ls_rs1(ls_rs1),
    .ls_rs2(ls_rs2), .free_count(free_count)
  );

  typedef struct {
    logic [5:0] op; bit is_ls; logic [3:0] tag; logic [31:0] imm;
    bit r1, r2; logic [3:0] q1, q2; logic [31:0] v1, v2;
  } ent_t;

  ent_t mq[$];
  bit m_av [NA];
  logic [73:0] m_ad [NA];
  bit m_lv;
  logic [105:0] m_ld;
  int total = 0, bad = 0;
  logic [105:0] snap;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic bit uses_imm(input logic [5:0] o);
    return o inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_ADDI,
                     OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
                     OP_SLLI, OP_SRLI, OP_SRAI};
  endfunction

  task automatic cdb_hit(input logic [3:0] t, output bit h,
                         output logic [31:0] v);
    h = 0; v = '0;
    for (int k = 0; k < NC; k++)
      if (!h && cdb_valid[k] && cdb_tag[k*TW +: TW] == t) begin
        h = 1; v = cdb_value[k*32 +: 32];
      end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int c = 0; c < NA; c++) m_av[c] = 0;
    m_lv = 0;
  endtask

  task automatic model_edge(input bit acc);
    ent_t keep[$];
    ent_t e;
    int ch;
    bit h, ls_open;
    logic [31:0] v;
    if (!rdy) return;
    if (flush) begin
      model_clear();
      return;
    end
    ch = 0;
    ls_open = ls_ready || !m_lv;
    if (ls_open) m_lv = 0;
    foreach (mq[i]) begin
      e = mq[i];
      if (e.r1 && e.r2 && !e.is_ls && ch < NA) begin
        m_av[ch] = 1; m_ad[ch] = {e.op, e.tag, e.v1, e.v2}; ch++;
      end else if (e.r1 && e.r2 && e.is_ls && ls_open && !m_lv) begin
        m_lv = 1; m_ld = {e.op, e.tag, e.imm, e.v1, e.v2};
      end else keep.push_back(e);
    end
    for (int c = ch; c < NA; c++) m_av[c] = 0;
    for (int i = 0; i < keep.size(); i++) begin
      if (!keep[i].r1) begin
        cdb_hit(keep[i].q1, h, v);
        if (h) begin keep[i].r1 = 1; keep[i].v1 = v; end
      end
      if (!keep[i].r2) begin
        cdb_hit(keep[i].q2, h, v);
        if (h) begin keep[i].r2 = 1; keep[i].v2 = v; end
      end
    end
    if (acc) begin
      e.op = disp_op; e.is_ls = disp_is_ls; e.tag = disp_tag;
      e.imm = disp_imm; e.q1 = disp_q1; e.q2 = disp_q2;
      e.r1 = !disp_q1_busy; e.v1 = disp_v1;
      if (disp_q1_busy) begin
        cdb_hit(disp_q1, h, v);
        if (h) begin e.r1 = 1; e.v1 = v; end
      end
      if (!disp_is_ls && uses_imm(disp_op)) begin
        e.r2 = 1; e.v2 = disp_imm;
      end else begin
        e.r2 = !disp_q2_busy; e.v2 = disp_v2;
        if (disp_q2_busy) begin
          cdb_hit(disp_q2, h, v);
          if (h) begin e.r2 = 1; e.v2 = v; end
        end
      end
      keep.push_back(e);
    end
    mq = keep;
  endtask

  task automatic check_outs();
    logic [NA-1:0] ev;
    chk("free_count", free_count, RS - mq.size());
    for (int c = 0; c < NA; c++) ev[c] = m_av[c];
    chk("alu_valid", alu_valid, ev);
    for (int c = 0; c < NA; c++)
      if (m_av[c])
        chk($sformatf("alu_data%0d", c),
            {alu_op[c*6 +: 6], alu_tag[c*TW +: TW],
             alu_rs1[c*32 +: 32], alu_rs2[c*32 +: 32]}, m_ad[c]);
    chk("ls_valid", ls_valid, m_lv);
    if (m_lv)
      chk("ls_data", {ls_op, ls_tag, ls_offset, ls_rs1, ls_rs2}, m_ld);
  endtask

  task automatic cycle();
    bit acc;
    #1;
    chk("disp_ready", disp_ready, (mq.size() < RS) && !flush);
    acc = disp_valid && (mq.size() < RS) && !flush && rdy;
    @(posedge clk);
    model_edge(acc);
    #1;
    check_outs();
  endtask

  task automatic idle();
    rdy = 1; flush = 0; ls_ready = 1; disp_valid = 0;
    disp_op = '0; disp_is_ls = 0; disp_tag = '0; disp_imm = '0;
    disp_q1_busy = 0; disp_q2_busy = 0; disp_q1 = '0; disp_q2 = '0;
    disp_v1 = '0; disp_v2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic nodisp();
    disp_valid = 0;
    cdb_valid = '0;
  endtask

  task automatic disp(input logic [5:0] o, input bit ls,
                      input logic [3:0] t, input logic [31:0] im,
                      input bit b1, input logic [3:0] a1,
                      input logic [31:0] x1, input bit b2,
                      input logic [3:0] a2, input logic [31:0] x2);
    disp_valid = 1; disp_op = o; disp_is_ls = ls; disp_tag = t;
    disp_imm = im; disp_q1_busy = b1; disp_q1 = a1; disp_v1 = x1;
    disp_q2_busy = b2; disp_q2 = a2; disp_v2 = x2;
  endtask

  task automatic set_cdb(input int k, input logic [3:0] t,
                         input logic [31:0] v);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*TW +: TW] = t;
    cdb_value[k*32 +: 32] = v;
  endtask

  initial begin
    idle();
    model_clear();
    rst = 0;
    #7;
    chk("rst_free", free_count, 5'd16);
    chk("rst_alu_valid", alu_valid, 2'b00);
    chk("rst_ls_valid", ls_valid, 1'b0);
    @(negedge clk) rst = 1;

    // ADD with both operands ready
    disp(OP_ADD, 0, 4'd3, 32'd0, 0, 4'd0, 32'd10, 0, 4'd0, 32'd20);
    cycle();
    chk("add_pending_free", free_count, 5'd15);
    nodisp(); cycle();
    chk("add_issue_v", alu_valid[0], 1'b1);
    chk("add_issue_tag", alu_tag[3:0], 4'd3);
    chk("add_free_back", free_count, 5'd16);
    cycle();

    // CDB wakeup on port 1
    disp(OP_ADD, 0, 4'd6, 32'd0, 1, 4'd5, 32'd0, 0, 4'd0, 32'd1);
    cycle();
    nodisp(); set_cdb(1, 4'd5, 32'h1234); cycle();
    chk("wake_not_yet", alu_valid, 2'b00);
    nodisp(); cycle();
    chk("wake_issue_v", alu_valid[0], 1'b1);
    chk("wake_rs1", alu_rs1[31:0], 32'h1234);

    // same-cycle bypass at dispatch
    disp(OP_ADD, 0, 4'd8, 32'd0, 1, 4'd7, 32'd0, 0, 4'd0, 32'd2);
    set_cdb(0, 4'd7, 32'hAB);
    cycle();
    nodisp(); cycle();
    chk("byp_issue_v", alu_valid[0], 1'b1);
    chk("byp_rs1", alu_rs1[31:0], 32'hAB);

    // three entries made ready together: oldest two first
    for (int t = 1; t <= 3; t++) begin
      disp(OP_SUB, 0, 4'(t), 32'd0, 1, 4'd9, 32'd0, 0, 4'd0, 32'(t));
      cycle();
    end
    nodisp(); set_cdb(0, 4'd9, 32'h99); cycle();
    nodisp(); cycle();
    chk("age_first_v", alu_valid, 2'b11);
    chk("age_first_tags", alu_tag, 8'h21);
    cycle();
    chk("age_second_v", alu_valid, 2'b01);
    chk("age_second_tag", alu_tag[3:0], 4'd3);
    cycle();

    // fill and load/store backpressure
    ls_ready = 0;
    disp(OP_LW, 1, 4'd10, 32'h40, 0, 4'd0, 32'h1000, 0, 4'd0, 32'd0);
    cycle();
    disp(OP_LW, 1, 4'd11, 32'h44, 0, 4'd0, 32'h2000, 0, 4'd0, 32'd0);
    cycle();
    for (int i = 0; i < 15; i++) begin
      disp(OP_ADD, 0, 4'd0, 32'd0, 1, 4'd12, 32'd0, 0, 4'd0, 32'(i));
      cycle();
    end
    nodisp(); #1;
    chk("full_ready", disp_ready, 1'b0);
    chk("full_free", free_count, 5'd0);
    snap = {ls_op, ls_tag, ls_offset, ls_rs1, ls_rs2};
    chk("ls_first_tag", ls_tag, 4'd10);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ls_hold", {ls_op, ls_tag, ls_offset, ls_rs1, ls_rs2}, snap);
    end
    ls_ready = 1; cycle();
    chk("ls_next_tag", ls_tag, 4'd11);
    chk("ls_next_v", ls_valid, 1'b1);
    cycle();

    // flush with ten busy entries and a concurrent dispatch
    flush = 1; cycle(); flush = 0;
    for (int i = 0; i < 10; i++) begin
      disp(OP_ADD, 0, 4'(i), 32'd0, 1, 4'd13, 32'd0, 0, 4'd0, 32'd0);
      cycle();
    end
    chk("pre_flush_free", free_count, 5'd6);
    disp(OP_ADD, 0, 4'd1, 32'd0, 0, 4'd0, 32'd1, 0, 4'd0, 32'd1);
    flush = 1; cycle();
    chk("flush_free", free_count, 5'd16);
    chk("flush_alu", alu_valid, 2'b00);
    flush = 0; nodisp(); cycle();
    chk("flush_no_issue", alu_valid, 2'b00);

    // reset mid-operation
    disp(OP_ADDI, 0, 4'd1, 32'h7, 0, 4'd0, 32'd5, 1, 4'd3, 32'd0);
    cycle();
    disp(OP_ADD, 0, 4'd2, 32'd0, 0, 4'd0, 32'd6, 0, 4'd0, 32'd8);
    cycle();
    chk("imm_rs2", alu_rs2[31:0], 32'h7);
    rst = 0; #2;
    chk("mid_rst_free", free_count, 5'd16);
    chk("mid_rst_alu", alu_valid, 2'b00);
    model_clear();
    @(negedge clk) rst = 1;
    idle(); cycle();
    chk("post_rst_alu", alu_valid, 2'b00);

    // random traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      rdy = ($urandom_range(0, 19) != 0);
      flush = ($urandom_range(0, 39) == 0);
      ls_ready = ($urandom_range(0, 9) < 6);
      if (rdy && $urandom_range(0, 9) < 6) begin
        int s;
        logic [5:0] o;
        s = $urandom_range(0, 5);
        o = (s == 0) ? OP_ADD : (s == 1) ? OP_SUB :
            (s == 2) ? OP_ADDI : (s == 3) ? OP_AND :
            (s == 4) ? OP_LW : OP_SW;
        disp(o, s >= 4, 4'($urandom_range(0, 15)), $urandom,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
             $urandom,
             $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
             $urandom);
      end
      for (int k = 0; k < NC; k++)
        if ($urandom_range(0, 1) == 1)
          set_cdb(k, 4'($urandom_range(0, 15)), $urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
